fp16_acc_stream: RTL and testbench

FP16_ACC_STREAM -- requirements
Module: fp16_acc_stream

---
 rtl/fp16_pkg.sv | 22 ++
 rtl/new_fp_16_add.sv | 120 ++++++++++++
 rtl/fp16_acc_stream.sv | 72 +++++++
 tb/tb_fp16_acc_stream.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the streaming accumulator slice.
//   EXP_BITS / MAN_BITS / BIAS : IEEE binary16 field layout (1-5-10)
//   EXP_MAX                    : all-ones exponent (inf / NaN)
//   FP16_ZERO / FP16_QNAN      : canonical +0 and quiet NaN encodings
//   state_e                    : accumulator FSM states
package fp16_pkg;

  localparam int unsigned EXP_BITS = 5;
  localparam int unsigned MAN_BITS = 10;
  localparam int unsigned BIAS     = 15;

  localparam logic [EXP_BITS-1:0] EXP_MAX   = EXP_BITS'(2 * BIAS + 1);
  localparam logic [15:0]         FP16_ZERO = 16'h0000;
  localparam logic [15:0]         FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/new_fp_16_add.sv
// Combinational FP16 adder, round-to-nearest-even, full subnormal support.
//   operands_i[1] : first operand (accumulator)
//   operands_i[0] : second operand (incoming element)
//   result_o      : FP16 sum; exact cancellation gives +0 (0x0000),
//                   overflow gives signed infinity, NaN inputs give QNAN.
module new_fp_16_add
  import fp16_pkg::*;
(
  input  logic [1:0][15:0] operands_i,
  output logic [15:0]      result_o
);

  localparam int unsigned SIG_W = MAN_BITS + 1;  // significand incl. hidden bit
  localparam int unsigned EXT_W = SIG_W + 3;     // plus guard, round, sticky

  logic [15:0]      op_a, op_b;
  logic [5:0]       exp_a, exp_b, exp_diff, exp_n, exp_r;
  logic [EXT_W-1:0] sig_a, sig_b, sig_b_sh, norm;
  logic [EXT_W:0]   sum;
  logic [5:0]       lz, lshift;
  logic             zero_res, round_up;
  logic [SIG_W:0]   rounded;
  logic [SIG_W-1:0] sig_f;
  logic [4:0]       exp_field;

  always_comb begin
    op_a      = operands_i[1];
    op_b      = operands_i[0];
    exp_a     = '0;
    exp_b     = '0;
    exp_diff  = '0;
    exp_n     = '0;
    exp_r     = '0;
    sig_a     = '0;
    sig_b     = '0;
    sig_b_sh  = '0;
    norm      = '0;
    sum       = '0;
    lz        = '0;
    lshift    = '0;
    zero_res  = 1'b0;
    round_up  = 1'b0;
    rounded   = '0;
    sig_f     = '0;
    exp_field = '0;
    result_o  = FP16_ZERO;

    // op_a always carries the larger magnitude, so the subtract never borrows
    if (operands_i[0][14:0] > operands_i[1][14:0]) begin
      op_a = operands_i[0];
      op_b = operands_i[1];
    end

    // subnormals use effective exponent 1 with a cleared hidden bit
    exp_a = (op_a[14:10] == '0) ? 6'd1 : {1'b0, op_a[14:10]};
    exp_b = (op_b[14:10] == '0) ? 6'd1 : {1'b0, op_b[14:10]};
    sig_a = {(op_a[14:10] != '0), op_a[9:0], 3'b000};
    sig_b = {(op_b[14:10] != '0), op_b[9:0], 3'b000};

    // align with all shifted-out bits folded into the sticky lsb
    exp_diff = exp_a - exp_b;
    if (exp_diff >= 6'(EXT_W)) begin
      sig_b_sh = {{(EXT_W-1){1'b0}}, |sig_b};
    end else begin
      sig_b_sh    = sig_b >> exp_diff;
      sig_b_sh[0] = sig_b_sh[0] | (|(sig_b & ~({EXT_W{1'b1}} << exp_diff)));
    end

    if (op_a[15] == op_b[15]) begin
      sum = {1'b0, sig_a} + {1'b0, sig_b_sh};
      if (sum[EXT_W]) begin
        norm  = {sum[EXT_W:2], sum[1] | sum[0]};
        exp_n = exp_a + 6'd1;
      end else begin
        norm  = sum[EXT_W-1:0];
        exp_n = exp_a;
      end
    end else begin
      sum = {1'b0, sig_a} - {1'b0, sig_b_sh};
      if (sum[EXT_W-1:0] == '0) begin
        zero_res = 1'b1;
      end
      lz = 6'(EXT_W);
      for (int unsigned i = 0; i < EXT_W; i++) begin
        if (sum[i]) lz = 6'(EXT_W - 1 - i);
      end
      // stop normalising at exponent 1 so the result lands as a subnormal
      lshift = (lz > exp_a - 6'd1) ? exp_a - 6'd1 : lz;
      norm   = sum[EXT_W-1:0] << lshift;
      exp_n  = exp_a - lshift;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
    if (rounded[SIG_W]) begin
      sig_f = rounded[SIG_W:1];
      exp_r = exp_n + 6'd1;
    end else begin
      sig_f = rounded[SIG_W-1:0];
      exp_r = exp_n;
    end
    exp_field = sig_f[SIG_W-1] ? exp_r[4:0] : 5'd0;

    if (op_a[14:10] == EXP_MAX) begin
      if ((op_a[9:0] != '0) ||
          ((op_b[14:0] == op_a[14:0]) && (op_a[15] != op_b[15]))) begin
        result_o = FP16_QNAN;
      end else begin
        result_o = op_a;
      end
    end else if (zero_res) begin
      result_o = FP16_ZERO;
    end else if (exp_r >= {1'b0, EXP_MAX}) begin
      result_o = {op_a[15], EXP_MAX, 10'd0};
    end else begin
      result_o = {op_a[15], exp_field, sig_f[MAN_BITS-1:0]};
    end
  end

endmodule

// File: rtl/fp16_acc_stream.sv
// Streaming FP16 vector accumulator.
// Sums the elements of each in_last_i-terminated vector and presents the
// sum with a saturating element count on a valid/ready output.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   in_valid_i/ready_o : element handshake; in_data_i element, in_last_i end
//   out_valid_o/ready_i: sum handshake; out_data_o sum, out_count_o count
module fp16_acc_stream
  import fp16_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_WIDTH-1:0]  out_count_o
);

  state_e                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]  count;
  logic                  in_fire;

  new_fp_16_add u_add (
    .operands_i ({acc, in_data_i}),
    .result_o   (sum)
  );

  assign in_ready_o  = (state != OUT);
  assign out_valid_o = (state == OUT);
  assign out_data_o  = acc;
  assign out_count_o = count;
  assign in_fire     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= FP16_ZERO;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // first element is loaded directly so no zero-add is needed
          if (in_fire) begin
            acc   <= in_data_i;
            count <= CNT_WIDTH'(1);
            state <= in_last_i ? OUT : ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc <= sum;
            if (count != '1) count <= count + CNT_WIDTH'(1);
            if (in_last_i) state <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_acc_stream.sv
module tb_fp16_acc_stream;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_data_i = 16'h0000;
  logic        in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
  logic [7:0]  out_count_o;

  int checks = 0;
  int errors = 0;

  localparam int NV = 9;
  localparam logic [15:0] VA [NV] = '{16'h3C00, 16'h0001, 16'h03FF, 16'h4000, 16'h3C01,
                                      16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF};
  localparam logic [15:0] VB [NV] = '{16'hBC00, 16'h0001, 16'h0001, 16'hBC00, 16'hBC00,
                                      16'h0001, 16'h1000, 16'h1000, 16'h7BFF};
  localparam logic [15:0] VS [NV] = '{16'h0000, 16'h0002, 16'h0400, 16'h3C00, 16'h1400,
                                      16'h3C00, 16'h3C00, 16'h3C02, 16'h7C00};

  fp16_acc_stream #(.CNT_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_count_o (out_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    checks++; if (out_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data_o); end
    checks++; if (out_count_o !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    send(16'h4200, 1'b1);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid_o); end
    checks++; if (out_data_o !== 16'h4200) begin errors++; $display("FAIL single_data: got %h expected 4200", out_data_o); end
    checks++; if (out_count_o !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", out_count_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL single_in_ready: got %b expected 0", in_ready_o); end
    drain();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_stream();
    int lows = 0;
    out_ready_i = 1'b1;
    send(16'h3C00, 1'b0);
    if (!in_ready_o) lows++;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b expected 0", out_valid_o); end
    send(16'h4000, 1'b0);
    if (!in_ready_o) lows++;
    send(16'h3800, 1'b1);
    if (!in_ready_o) lows++;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b expected 1", out_valid_o); end
    checks++; if (out_data_o !== 16'h4300) begin errors++; $display("FAIL stream_data: got %h expected 4300", out_data_o); end
    checks++; if (out_count_o !== 8'd3) begin errors++; $display("FAIL stream_count: got %0d expected 3", out_count_o); end
    for (int i = 0; i < 2; i++) begin
      step();
      if (!in_ready_o) lows++;
    end
    out_ready_i = 1'b0;
    checks++; if (lows !== 1) begin errors++; $display("FAIL stream_in_ready_low_cycles: got %0d expected 1", lows); end
  endtask

  task automatic test_adder_vectors();
    for (int i = 0; i < NV; i++) begin
      send(VA[i], 1'b0);
      send(VB[i], 1'b1);
      checks++; if (out_data_o !== VS[i]) begin errors++; $display("FAIL vec%0d_data: %h+%h got %h expected %h", i, VA[i], VB[i], out_data_o, VS[i]); end
      checks++; if (out_count_o !== 8'd2) begin errors++; $display("FAIL vec%0d_count: got %0d expected 2", i, out_count_o); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    in_valid_i = 1'b1;
    in_data_i  = 16'h5555;
    in_last_i  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, out_valid_o); end
      checks++; if (out_data_o !== 16'h4200) begin errors++; $display("FAIL bp_data_c%0d: got %h expected 4200", c, out_data_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready_o); end
      step();
    end
    checks++; if (out_count_o !== 8'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", out_count_o); end
    out_ready_i = 1'b1;
    step();
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_transfer: got %b expected 0", out_valid_o); end
    checks++; if (out_data_o !== 16'h4200) begin errors++; $display("FAIL bp_not_consumed_data: got %h expected 4200", out_data_o); end
    checks++; if (out_count_o !== 8'd2) begin errors++; $display("FAIL bp_not_consumed_count: got %0d expected 2", out_count_o); end
  endtask

  task automatic test_gaps();
    send(16'h3C00, 1'b0);
    for (int g = 0; g < 2; g++) begin
      in_last_i = 1'b1;
      step();
      in_last_i = 1'b0;
      checks++; if (out_data_o !== 16'h3C00) begin errors++; $display("FAIL gap%0d_acc: got %h expected 3c00", g, out_data_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL gap%0d_valid: got %b expected 0", g, out_valid_o); end
    end
    send(16'h4000, 1'b0);
    send(16'h3800, 1'b1);
    checks++; if (out_data_o !== 16'h4300) begin errors++; $display("FAIL gaps_data: got %h expected 4300", out_data_o); end
    checks++; if (out_count_o !== 8'd3) begin errors++; $display("FAIL gaps_count: got %0d expected 3", out_count_o); end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send(16'h0001, (i == 299));
    checks++; if (out_data_o !== 16'h012C) begin errors++; $display("FAIL sat_data: got %h expected 012c", out_data_o); end
    checks++; if (out_count_o !== 8'hFF) begin errors++; $display("FAIL sat_count: got %0d expected 255", out_count_o); end
    drain();
  endtask

  task automatic test_reset_mid();
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", out_valid_o); end
    checks++; if (out_data_o !== 16'h0000) begin errors++; $display("FAIL rmid_data: got %h expected 0000", out_data_o); end
    checks++; if (out_count_o !== 8'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", out_count_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready_o); end
    #1 rst_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 16'h4000;
    in_last_i  = 1'b1;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rnew_valid: got %b expected 1", out_valid_o); end
    checks++; if (out_data_o !== 16'h4000) begin errors++; $display("FAIL rnew_data: got %h expected 4000", out_data_o); end
    checks++; if (out_count_o !== 8'd1) begin errors++; $display("FAIL rnew_count: got %0d expected 1", out_count_o); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_adder_vectors();
    test_backpressure();
    test_gaps();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
